// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-type codes and the writeback-stage register layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    LT_W  = 3'd0,
    LT_H  = 3'd1,
    LT_HU = 3'd2,
    LT_B  = 3'd3,
    LT_BU = 3'd4
  } load_type_e;

  // Load type is kept as a raw 3-bit code so that illegal codes 5-7 survive into W
  // and are decoded there as a word load.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic [2:0]  loadtype;
    logic [1:0]  addr_lo;
    logic [4:0]  wa;
    logic [31:0] aluout;
    logic [31:0] rdata;
  } w_reg_t;

endpackage

// File: rtl/wb_stage_if.sv
// M->W pipeline slot and register-file write/retire signals of the writeback stage.
interface wb_stage_if;
  logic        m_valid;
  logic        m_regwrite;
  logic        m_memtoreg;
  logic [2:0]  m_loadtype;
  logic [1:0]  m_addr_lo;
  logic [4:0]  m_wa;
  logic [31:0] m_aluout;
  logic [31:0] m_rdata;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        addr_err;
  logic [31:0] instret;

  modport master (
    output m_valid, m_regwrite, m_memtoreg, m_loadtype, m_addr_lo, m_wa, m_aluout, m_rdata,
    input  we3, wa3, wd3, addr_err, instret
  );

  modport slave (
    input  m_valid, m_regwrite, m_memtoreg, m_loadtype, m_addr_lo, m_wa, m_aluout, m_rdata,
    output we3, wa3, wd3, addr_err, instret
  );
endinterface

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a little-endian load word,
// plus alignment check for the selected load type.
module load_extract
  import cpu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_loadtype,
  output logic [31:0] o_value,
  output logic        o_misaligned
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    o_value      = i_rdata;
    o_misaligned = 1'b0;
    case (i_loadtype)
      LT_H: begin
        o_value      = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      LT_HU: begin
        o_value      = {16'h0000, w_half};
        o_misaligned = i_addr_lo[0];
      end
      LT_B:    o_value = {{24{w_byte[7]}}, w_byte};
      LT_BU:   o_value = {24'h000000, w_byte};
      default: o_misaligned = (i_addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage: W register, load extraction, register-file write port
// and retired-instruction counter.
module wb_stage
  import cpu_pkg::*;
(
  input  logic CLK,
  input  logic reset,
  input  logic stall,
  input  logic flush,
  wb_stage_if.slave bus
);

  w_reg_t      r_w;
  logic [31:0] r_instret;
  w_reg_t      w_m;
  logic [31:0] w_ld_value;
  logic        w_misaligned;
  logic        w_addr_err;

  assign w_m = '{valid:    bus.m_valid,
                 regwrite: bus.m_regwrite,
                 memtoreg: bus.m_memtoreg,
                 loadtype: bus.m_loadtype,
                 addr_lo:  bus.m_addr_lo,
                 wa:       bus.m_wa,
                 aluout:   bus.m_aluout,
                 rdata:    bus.m_rdata};

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_w       <= '0;
      r_instret <= '0;
    end else begin
      // An instruction retires when it leaves W: on a normal advance or when flushed out.
      if (r_w.valid && (!stall || flush))
        r_instret <= r_instret + 32'd1;
      if (flush)
        r_w.valid <= 1'b0;
      else if (!stall)
        r_w <= w_m;
    end
  end

  load_extract u_load_extract (
    .i_rdata      (r_w.rdata),
    .i_addr_lo    (r_w.addr_lo),
    .i_loadtype   (r_w.loadtype),
    .o_value      (w_ld_value),
    .o_misaligned (w_misaligned)
  );

  assign w_addr_err   = r_w.valid & r_w.memtoreg & w_misaligned;
  assign bus.addr_err = w_addr_err;
  assign bus.we3      = r_w.valid & r_w.regwrite & (r_w.wa != 5'd0) & ~w_addr_err;
  assign bus.wa3      = r_w.wa;
  assign bus.wd3      = r_w.memtoreg ? w_ld_value : r_w.aluout;
  assign bus.instret  = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed M-slot vectors push expected W outputs,
// a negedge monitor pops and compares them.
module tb_wb_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic [2:0]  loadtype;
    logic [1:0]  addr_lo;
    logic [4:0]  wa;
    logic [31:0] aluout;
    logic [31:0] rdata;
  } m_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        addr_err;
    logic [31:0] instret;
    logic        chk_data;
  } exp_t;

  logic CLK;
  logic reset;
  logic stall;
  logic flush;
  wb_stage_if bus ();

  wb_stage dut (
    .CLK   (CLK),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  logic [31:0] rf [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Register-file model: samples the write port on the falling edge.
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(negedge CLK) if (bus.we3 === 1'b1) rf[bus.wa3] = bus.wd3;

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("c%0d.we3", e.tag), {31'b0, bus.we3}, {31'b0, e.we3});
        check($sformatf("c%0d.addr_err", e.tag), {31'b0, bus.addr_err}, {31'b0, e.addr_err});
        check($sformatf("c%0d.instret", e.tag), bus.instret, e.instret);
        if (e.chk_data) begin
          check($sformatf("c%0d.wa3", e.tag), {27'b0, bus.wa3}, {27'b0, e.wa3});
          check($sformatf("c%0d.wd3", e.tag), bus.wd3, e.wd3);
        end
      end
    end
  end

  function automatic m_t alu(input logic v, input logic [4:0] wa, input logic [31:0] d);
    alu = '{valid: v, regwrite: 1'b1, memtoreg: 1'b0, loadtype: 3'd0, addr_lo: 2'd0,
            wa: wa, aluout: d, rdata: 32'h0};
  endfunction

  function automatic m_t ld(input logic [2:0] lt, input logic [1:0] lo, input logic [4:0] wa,
                            input logic [31:0] rd);
    ld = '{valid: 1'b1, regwrite: 1'b1, memtoreg: 1'b1, loadtype: lt, addr_lo: lo,
           wa: wa, aluout: 32'hCAFE_0000, rdata: rd};
  endfunction

  function automatic exp_t ex(input logic [7:0] tag, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic ae, input logic [31:0] ir,
                              input logic chk);
    ex = '{tag: tag, we3: we, wa3: wa, wd3: wd, addr_err: ae, instret: ir, chk_data: chk};
  endfunction

  task automatic cycle(input logic rs, input logic st, input logic fl, input m_t m,
                       input exp_t e);
    reset          = rs;
    stall          = st;
    flush          = fl;
    bus.m_valid    = m.valid;
    bus.m_regwrite = m.regwrite;
    bus.m_memtoreg = m.memtoreg;
    bus.m_loadtype = m.loadtype;
    bus.m_addr_lo  = m.addr_lo;
    bus.m_wa       = m.wa;
    bus.m_aluout   = m.aluout;
    bus.m_rdata    = m.rdata;
    @(posedge CLK);
    #1;
    exp_q.push_back(e);
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    m_t idle;
    idle = alu(1'b0, 5'd0, 32'h0);
    idle.regwrite = 1'b0;

    cycle(1, 0, 0, idle,                          ex(0, 0, 5'd0, 32'h0, 0, 0, 1));
    // Capture ALU result, one-cycle latency, instret 0->1 on the following edge
    cycle(0, 0, 0, alu(1, 5'd5, 32'h1234_5678),   ex(1, 1, 5'd5, 32'h1234_5678, 0, 0, 1));
    cycle(0, 0, 0, ld(LT_B, 2'd3, 5'd6, RD),      ex(2, 1, 5'd6, 32'hFFFF_FF80, 0, 1, 1));
    check("rf5_written", rf[5], 32'h1234_5678);
    cycle(0, 0, 0, ld(LT_BU, 2'd3, 5'd6, RD),     ex(3, 1, 5'd6, 32'h0000_0080, 0, 2, 1));
    cycle(0, 0, 0, ld(LT_H, 2'd2, 5'd7, RD),      ex(4, 1, 5'd7, 32'hFFFF_80FF, 0, 3, 1));
    // Misaligned word load: no write, but it still retires
    cycle(0, 0, 0, ld(LT_W, 2'd2, 5'd9, RD),      ex(5, 0, 5'd9, RD, 1, 4, 1));
    cycle(0, 0, 0, ld(LT_B, 2'd1, 5'd10, RD),     ex(6, 1, 5'd10, 32'h0000_007F, 0, 5, 1));
    cycle(0, 0, 0, ld(3'd5, 2'd0, 5'd11, RD),     ex(7, 1, 5'd11, RD, 0, 6, 1));
    cycle(0, 0, 0, alu(1, 5'd0, 32'hDEAD_BEEF),   ex(8, 0, 5'd0, 32'hDEAD_BEEF, 0, 7, 1));
    // Stall with instret=7, then reset while still stalled
    cycle(0, 1, 0, alu(1, 5'd13, 32'h1111_1111),  ex(9, 0, 5'd0, 32'hDEAD_BEEF, 0, 7, 1));
    cycle(1, 1, 0, alu(1, 5'd13, 32'h1111_1111),  ex(10, 0, 5'd0, 32'h0, 0, 0, 1));
    check("rf0_zero", rf[0], 32'h0);
    // Three-cycle stall on a valid W
    cycle(0, 0, 0, alu(1, 5'd12, 32'hA5A5_0003),  ex(11, 1, 5'd12, 32'hA5A5_0003, 0, 0, 1));
    cycle(0, 1, 0, alu(1, 5'd13, 32'h1111_1111),  ex(12, 1, 5'd12, 32'hA5A5_0003, 0, 0, 1));
    cycle(0, 1, 0, alu(1, 5'd13, 32'h1111_1111),  ex(13, 1, 5'd12, 32'hA5A5_0003, 0, 0, 1));
    cycle(0, 1, 0, alu(1, 5'd13, 32'h1111_1111),  ex(14, 1, 5'd12, 32'hA5A5_0003, 0, 0, 1));
    cycle(0, 0, 0, alu(1, 5'd13, 32'h1111_1111),  ex(15, 1, 5'd13, 32'h1111_1111, 0, 1, 1));
    // Flush beats stall: bubble, flushed instruction still counted
    cycle(0, 1, 1, alu(1, 5'd14, 32'h2222_2222),  ex(16, 0, 5'd0, 32'h0, 0, 2, 0));
    cycle(0, 0, 0, alu(0, 5'd15, 32'h0),          ex(17, 0, 5'd15, 32'h0, 0, 2, 1));
    cycle(0, 0, 0, ld(LT_H, 2'd0, 5'd16, 32'h0000_8001),
                                                  ex(18, 1, 5'd16, 32'hFFFF_8001, 0, 2, 1));
    cycle(0, 0, 0, idle,                          ex(19, 0, 5'd0, 32'h0, 0, 3, 1));
    check("rf12_written", rf[12], 32'hA5A5_0003);

    @(negedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter LT_W..LT_BU: load-type codes from cpu_pkg (LT_W=0, LT_H=1, LT_HU=2, LT_B=3, LT_BU=4); codes 5-7 are illegal and treated as LT_W.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold W register contents this cycle.
REQ-005 flush  input  1  load a bubble into W this cycle.
REQ-006 m_valid  input  1  M-stage slot holds a real instruction.
REQ-007 m_regwrite  input  1  instruction writes a GPR.
REQ-008 m_memtoreg  input  1  1 = result from load data, 0 = from ALU.
REQ-009 m_loadtype  input  3  load type code.
REQ-010 m_addr_lo  input  2  effective address bits [1:0].
REQ-011 m_wa  input  5  destination register number.
REQ-012 m_aluout  input  32  ALU result.
REQ-013 m_rdata  input  32  raw data-memory word, little-endian lanes.
REQ-014 we3  output  1  register-file write enable.
REQ-015 wa3  output  5  register-file write address.
REQ-016 wd3  output  32  register-file write data; also the forwarding source.
REQ-017 addr_err  output  1  W holds a misaligned load.
REQ-018 instret  output  32  retired-instruction counter.

Function
REQ-019 Posedge priority: reset > flush > stall > capture.
REQ-020 Capture: W register takes all m_* fields; latency M->W is exactly one cycle.
REQ-021 Stall: every W field, including valid, holds its value.
REQ-022 Flush: W valid <= 0; other fields don't-care.
REQ-023 Flush with stall asserted: flush wins and W becomes a bubble.
REQ-024 Misaligned condition: LT_W with addr_lo != 0, or LT_H/LT_HU with addr_lo[0] = 1.
REQ-025 addr_err = W valid & W memtoreg & misaligned; combinational from W register.
REQ-026 we3 = W valid & W regwrite & (W wa != 0) & !addr_err.
REQ-027 wa3 = W wa, unconditionally.
REQ-028 wd3 = W aluout when memtoreg = 0, otherwise the extracted load value.
REQ-029 Load extraction for LT_W: whole word.
REQ-030 Load extraction for LT_H/LT_HU: halfword at bits [16*addr_lo[1] +: 16].
REQ-031 Load extraction for LT_B/LT_BU: byte at bits [8*addr_lo +: 8].
REQ-032 LT_H and LT_B sign-extend to 32 bits; LT_HU and LT_BU zero-extend.
REQ-033 we3 and wd3 stay asserted for the full cycle; the register file samples them on negedge CLK, so a write is visible to same-cycle reads by the next posedge.
REQ-034 During stall, we3 stays asserted while W is valid; repeated writes of the same value are permitted.
REQ-035 instret increments by 1 on a posedge where W valid = 1 and (stall = 0 or flush = 1).
REQ-036 instret counts instructions with addr_err and instructions with wa = 0.
REQ-037 instret wraps modulo 2^32 with no flag.

Reset
REQ-038 On reset: W valid, instret, we3 and addr_err = 0.
REQ-039 On reset: wa3 = 0 and wd3 = 0, with all W data fields cleared.
REQ-040 Reset mid-stall discards the held instruction without counting it.

Structure
REQ-041 cpu_pkg holds the load-type enum and the LT_* constants.
REQ-042 One sub-module, load_extract: combinational (rdata, addr_lo, loadtype) -> 32-bit value plus misaligned flag.
REQ-043 No other state is allowed beyond the W register and the instret counter.

Verification
REQ-044 Scenario 1: capture m_valid=1, regwrite=1, memtoreg=0, wa=5, aluout=0x1234_5678 -> next cycle we3=1, wa3=5, wd3=0x12345678, and instret 0->1 on the following edge.
REQ-045 Scenario 2: rdata=0x80FF_7F01, LT_B, addr_lo=3 -> wd3=0xFFFFFF80; with LT_BU -> 0x00000080; with LT_H, addr_lo=2 -> 0xFFFF80FF.
REQ-046 Scenario 3: LT_W with addr_lo=2, wa=9 -> addr_err=1, we3=0, and instret still increments.
REQ-047 Scenario 4: regwrite=1, wa=0, aluout=0xDEAD_BEEF -> we3=0 and register 0 still reads 0.
REQ-048 Scenario 5: stall held 3 cycles on a valid W -> outputs stable, instret +1 only after stall drops; flush+stall together -> bubble next cycle, we3=0.
REQ-049 Scenario 6: reset asserted mid-stall with instret=7 -> next cycle instret=0 and all outputs 0.
